stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline stall and flush controller for the five-stage core. It produces the hold enables consumed by the stall-capable pipeline flops (1 = hold), the ID/EX bubble and the IF/ID flush. It detects load-use hazards, holds the pipeline while a multi-cycle data-memory access is pending, and latches a sticky error if memory never answers. It sits beside the decode stage and is driven by ID, EX and MEM stage signals.

## Interface

- REG_W, 3, register specifier width
- MEM_TIMEOUT, 16, max wait cycles after mem_req before error (≥2)
- CNT_W, 16, stall performance counter width

Ports:

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  REG_W  source specifiers of instruction in ID
- id_rs_use, id_rt_use  in  1  corresponding source actually read
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination of instruction in EX
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_req  in  1  MEM stage starts a data access this cycle
- mem_done  in  1  data memory completes the access this cycle
- stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1  hold enables, 1 = register keeps value
- bubble_idex  out  1  load NOP control into ID/EX
- flush_ifid  out  1  load NOP into IF/ID
- mem_timeout_err  out  1  sticky memory timeout
- stall_count  out  CNT_W  cycles with stall_pc = 1, saturating

## Operation

- FSM states: RUN, MEM_WAIT, ERR.
- RUN, mem_req=1, mem_done=0: assert all five stall_* this cycle; next state MEM_WAIT, wait_cnt←1.
- RUN, mem_req=1, mem_done=1: single-cycle access, no memory stall.
- MEM_WAIT, mem_done=0: all stall_*=1; if wait_cnt==MEM_TIMEOUT → ERR, else wait_cnt+1.
- MEM_WAIT, mem_done=1: all stall_*=0 this cycle (pipeline advances); next RUN.
- ERR: all stall_*=1, mem_timeout_err=1, bubble/flush 0; exits only on reset.
- Load-use hazard (combinational): ex_memread && ((id_rs_use && id_rs==ex_rd) || (id_rt_use && id_rt==ex_rd)). Result: stall_pc=stall_ifid=1, bubble_idex=1, other stalls 0. All registers, including r0, are compared.
- Taken branch: flush_ifid=1, bubble_idex=1, no stall_*. PC loads target.
- Priority: memory stall (incl. ERR) > taken branch > load-use. A suppressed branch re-presents itself because EX is held.
- stall_count increments each cycle stall_pc=1 and saturates at all-ones.

## Timing

- While rst=0: state RUN, wait_cnt 0, mem_timeout_err 0, stall_count 0. All stall_*, bubble_idex and flush_ifid are forced 0.
- All hold/bubble/flush outputs are combinational from state plus same-cycle inputs, with zero latency. Registered state updates at the next rising edge.
- A memory access finishing on wait cycle MEM_TIMEOUT is legal. ERR is entered at the edge ending that cycle only if mem_done=0.
- mem_req is ignored outside RUN.
- Reset asserted mid-MEM_WAIT or in ERR: immediate return to reset values, with no completion pulse.

## Structure

- Package stall_pkg holds the state encoding (RUN/MEM_WAIT/ERR) and the default REG_W.
- Sub-module lu_hazard_detect is purely combinational and produces the load-use flag. The FSM, wait counter and perf counter stay in stall_ctrl.

## Test plan

- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_use=1 → stall_pc=stall_ifid=bubble_idex=1, others 0, stall_count +1. Same inputs with id_rs_use=0 → no stall.
- Memory wait: mem_req with mem_done 4 cycles later → five stall_* high for 4 cycles, low on the done cycle. stall_count=4, state back to RUN.
- Timeout: MEM_TIMEOUT=16, mem_done never asserted → mem_timeout_err=1 from the 17th cycle after mem_req. Stalls stay high; rst low clears everything.
- Boundary: mem_done on exactly wait cycle 16 → no error, pipeline resumes.
- Priority: ex_branch_taken during MEM_WAIT → flush_ifid=0 until mem_done. Taken branch plus load-use together → flush_ifid=1, bubble_idex=1, stall_pc=0.
- Saturation: CNT_W=4, 20 stall cycles → stall_count holds at 15.

Source files
------------

// File: rtl/stall_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package stall_pkg;

  // Default register-specifier width for the five-stage core.
  localparam int REG_W_DEF = 3;

  // Controller states: normal flow, waiting on data memory, stuck after a timeout.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

endpackage

// File: rtl/lu_hazard_detect.sv
// Combinational load-use hazard detector: the instruction in ID reads a
// register that the load currently in EX has not produced yet.
module lu_hazard_detect
  import stall_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rs_use_i,
  input  logic             id_rt_use_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             hazard_o
);

  // Register 0 is compared like any other register; the core does not special-case it here.
  assign hazard_o = ex_memread_i &&
                    ((id_rs_use_i && (id_rs_i == ex_rd_i)) ||
                     (id_rt_use_i && (id_rt_i == ex_rd_i)));

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall and flush controller. Priority of causes:
// memory stall (including the error state) > taken branch > load-use.
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              mem_stall;
  logic              lu_hazard;

  lu_hazard_detect #(
    .REG_W (REG_W)
  ) u_lu_hazard_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rs_use_i  (id_rs_use),
    .id_rt_use_i  (id_rt_use),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .hazard_o     (lu_hazard)
  );

  // Memory-wait FSM: next state, wait counter and whether memory holds the pipe.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        // A request answered in the same cycle costs nothing.
        if (mem_req && !mem_done) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // mem_req is ignored here; only completion or the timeout moves us on.
        if (mem_done) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        // Only reset leaves the error state.
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Hold/bubble/flush outputs by priority; all forced low while reset is asserted.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        stall_memwb = 1'b1;
      end else if (ex_branch_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (lu_hazard) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_pc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and perf counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_timeout_err = (state_q == ERR);
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: a cycle-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_stall_ctrl;

  localparam int REG_W       = 3;
  localparam int MEM_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic             id_rs_use = 1'b0, id_rt_use = 1'b0, ex_memread = 1'b0;
  logic             ex_branch_taken = 1'b0, mem_req = 1'b0, mem_done = 1'b0;

  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, bub, fl, err;
  logic [15:0] cnt16;
  logic t_pc, t_ifid, t_idex, t_exmem, t_memwb, t_bub, t_fl, t_err;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stall_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use),
    .id_rt_use(id_rt_use), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_done(mem_done),
    .stall_pc(s_pc), .stall_ifid(s_ifid), .stall_idex(s_idex), .stall_exmem(s_exmem),
    .stall_memwb(s_memwb), .bubble_idex(bub), .flush_ifid(fl),
    .mem_timeout_err(err), .stall_count(cnt16)
  );

  stall_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use),
    .id_rt_use(id_rt_use), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_done(mem_done),
    .stall_pc(t_pc), .stall_ifid(t_ifid), .stall_idex(t_idex), .stall_exmem(t_exmem),
    .stall_memwb(t_memwb), .bubble_idex(t_bub), .flush_ifid(t_fl),
    .mem_timeout_err(t_err), .stall_count(cnt4)
  );

  // Output bundles: {pc, ifid, idex, exmem, memwb, bubble, flush, err}
  wire [7:0] dut_vec  = {s_pc, s_ifid, s_idex, s_exmem, s_memwb, bub, fl, err};
  wire [7:0] dut4_vec = {t_pc, t_ifid, t_idex, t_exmem, t_memwb, t_bub, t_fl, t_err};

  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_MEM  = 8'b1111_1000;
  localparam logic [7:0] V_ERR  = 8'b1111_1001;
  localparam logic [7:0] V_LU   = 8'b1100_0100;
  localparam logic [7:0] V_BR   = 8'b0000_0110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the outstanding request by the cycle it was issued, an error flag
  // and an unbounded stall-cycle total.
  bit m_err     = 1'b0;
  bit m_pending = 1'b0;
  int m_req_cyc = 0;
  int m_cyc     = 0;
  int m_cnt     = 0;

  logic       hold_mem, lu;
  logic [7:0] exp_vec;

  always_comb begin
    exp_vec  = V_IDLE;
    hold_mem = 1'b0;
    lu       = 1'b0;
    if (rst) begin
      hold_mem = m_err || (m_pending ? !mem_done : (mem_req && !mem_done));
      lu = ex_memread && ((id_rs_use && id_rs == ex_rd) || (id_rt_use && id_rt == ex_rd));
      if (hold_mem)             exp_vec = m_err ? V_ERR : V_MEM;
      else if (ex_branch_taken) exp_vec = V_BR;
      else if (lu)              exp_vec = V_LU;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_err     <= 1'b0;
      m_pending <= 1'b0;
      m_req_cyc <= 0;
      m_cyc     <= 0;
      m_cnt     <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (exp_vec[7]) m_cnt <= m_cnt + 1;
      if (!m_err) begin
        if (m_pending) begin
          if (mem_done) m_pending <= 1'b0;
          else if (m_cyc - m_req_cyc >= MEM_TIMEOUT) m_err <= 1'b1;
        end else if (mem_req && !mem_done) begin
          m_pending <= 1'b1;
          m_req_cyc <= m_cyc;
        end
      end
    end
  end

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    check("outputs", 32'(dut_vec), 32'(exp_vec));
    check("outputs_w4", 32'(dut4_vec), 32'(exp_vec));
    check("stall_count", 32'(cnt16), 32'(sat(m_cnt, 65535)));
    check("stall_count_w4", 32'(cnt4), 32'(sat(m_cnt, 15)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_rs_use = 1'b0; id_rt_use = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [2:0] rd, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu);
    idle();
    ex_memread = 1'b1; ex_rd = rd;
    id_rs = rs; id_rs_use = rsu; id_rt = rt; id_rt_use = rtu;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs forced low even with hazard-producing inputs present.
    idle();
    mem_req = 1'b1; ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_use = 1'b1;
    @(negedge clk);
    check("reset_outs", 32'(dut_vec), 32'(V_IDLE));
    check("reset_count", 32'(cnt16), 0);
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();

    // Load-use on rs.
    load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    check("lu_rs", 32'(dut_vec), 32'(V_LU));
    next_cycle();
    idle();
    @(negedge clk);
    check("lu_count", 32'(cnt16), 1);
    next_cycle();

    // Same specifiers but source not read: no hazard.
    load_use(3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check("lu_rs_unused", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();
    // Hazard via rt, via r0, and a non-matching register.
    load_use(3'd5, 3'd1, 1'b1, 3'd5, 1'b1);
    @(negedge clk);
    check("lu_rt", 32'(dut_vec), 32'(V_LU));
    next_cycle();
    load_use(3'd0, 3'd0, 1'b1, 3'd7, 1'b0);
    @(negedge clk);
    check("lu_r0", 32'(dut_vec), 32'(V_LU));
    next_cycle();
    load_use(3'd2, 3'd3, 1'b1, 3'd4, 1'b1);
    @(negedge clk);
    check("lu_nomatch", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();

    // Memory wait: request, done four cycles later.
    idle(); mem_req = 1'b1;
    @(negedge clk);
    check("memwait_req", 32'(dut_vec), 32'(V_MEM));
    next_cycle();
    for (int i = 1; i < 4; i++) begin
      idle();
      @(negedge clk);
      check("memwait_hold", 32'(dut_vec), 32'(V_MEM));
      next_cycle();
    end
    idle(); mem_done = 1'b1;
    @(negedge clk);
    check("memwait_done", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();
    idle();
    @(negedge clk);
    check("memwait_count", 32'(cnt16), 7);
    check("memwait_back_run", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();

    // Single-cycle access: no stall.
    idle(); mem_req = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    check("single_cycle", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();

    // Boundary: done on exactly wait cycle 16; mem_req held high is ignored in the wait.
    idle(); mem_req = 1'b1;
    next_cycle();
    for (int i = 1; i < MEM_TIMEOUT; i++) begin
      idle(); mem_req = 1'b1;
      next_cycle();
    end
    idle(); mem_done = 1'b1;
    @(negedge clk);
    check("boundary_done", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();
    idle();
    @(negedge clk);
    check("boundary_no_err", 32'(err), 0);
    check("boundary_count", 32'(cnt16), 23);
    next_cycle();

    // Taken branch while memory is pending: suppressed until the done cycle.
    idle(); mem_req = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      idle(); ex_branch_taken = 1'b1;
      @(negedge clk);
      check("branch_in_wait", 32'(dut_vec), 32'(V_MEM));
      next_cycle();
    end
    idle(); ex_branch_taken = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    check("branch_at_done", 32'(dut_vec), 32'(V_BR));
    next_cycle();

    // Taken branch beats load-use.
    load_use(3'd6, 3'd6, 1'b1, 3'd0, 1'b0);
    ex_branch_taken = 1'b1;
    @(negedge clk);
    check("branch_over_lu", 32'(dut_vec), 32'(V_BR));
    check("count_before_timeout", 32'(cnt16), 26);
    check("count_saturated_w4", 32'(cnt4), 15);
    next_cycle();

    // Timeout: mem_done never arrives.
    idle(); mem_req = 1'b1;
    next_cycle();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      idle();
      @(negedge clk);
      if (i == MEM_TIMEOUT) check("timeout_last_wait", 32'(dut_vec), 32'(V_MEM));
      next_cycle();
    end
    idle(); ex_branch_taken = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    check("timeout_err", 32'(dut_vec), 32'(V_ERR));
    next_cycle();
    idle(); mem_req = 1'b1;
    @(negedge clk);
    check("err_sticky", 32'(dut_vec), 32'(V_ERR));
    #1 rst = 1'b0;
    #1;
    check("err_reset_outs", 32'(dut_vec), 32'(V_IDLE));
    check("err_reset_count", 32'(cnt16), 0);
    next_cycle();
    idle(); rst = 1'b1;
    next_cycle();

    // Reset in the middle of a memory wait: no completion pulse afterwards.
    idle(); mem_req = 1'b1;
    next_cycle();
    idle();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("wait_reset_outs", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("wait_reset_run", 32'(dut_vec), 32'(V_IDLE));
    next_cycle();
    load_use(3'd1, 3'd1, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    check("after_reset_lu", 32'(dut_vec), 32'(V_LU));
    next_cycle();
    idle();
    @(negedge clk);
    check("after_reset_count", 32'(cnt16), 1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
